// File: rtl/cic_agc_pkg.sv
// cic_agc_pkg
// Shared definitions for the CIC automatic gain controller:
//   - agc_state_e : controller states (2-bit encoding)
//   - ctr_width() : width of a counter that must hold 0..max_count
package cic_agc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DECIDE  = 2'd2,
    SETTLE  = 2'd3
  } agc_state_e;

  // Never returns less than 1 so degenerate counts still give a legal vector.
  function automatic int ctr_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/cic_agc_peak.sv
// cic_agc_peak
// Magnitude extraction and running block-peak tracker for the AGC.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   sample     : signed CIC output sample (BITS)
//   tick       : sample is to be included in the running measurement
//   clear      : restart the measurement on the next cycle
//   run_peak   : running peak including the current sample when tick=1 (BITS-1, unsigned)
//   run_clip   : running full-scale flag including the current sample when tick=1
module cic_agc_peak
  import cic_agc_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [BITS-1:0] sample,
  input  logic            tick,
  input  logic            clear,
  output logic [BITS-2:0] run_peak,
  output logic            run_clip
);

  localparam logic [BITS-1:0] FS_POS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] FS_NEG = {1'b1, {(BITS-1){1'b0}}};

  logic [BITS-1:0] abs_val;
  logic [BITS-2:0] mag;
  logic            full_scale;
  logic [BITS-2:0] peak_q, peak_d;
  logic            clip_q, clip_d;

  // Two's complement absolute value; the most negative code has no positive
  // counterpart, so it saturates to the largest positive magnitude.
  always_comb begin
    abs_val    = sample[BITS-1] ? (~sample + BITS'(1)) : sample;
    mag        = abs_val[BITS-1] ? '1 : abs_val[BITS-2:0];
    full_scale = (sample == FS_POS) || (sample == FS_NEG);
    run_peak   = peak_q;
    run_clip   = clip_q;
    if (tick) begin
      if (mag > peak_q) begin
        run_peak = mag;
      end
      run_clip = clip_q | full_scale;
    end
    peak_d = clear ? '0 : run_peak;
    clip_d = clear ? 1'b0 : run_clip;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak_q <= '0;
      clip_q <= 1'b0;
    end else begin
      peak_q <= peak_d;
      clip_q <= clip_d;
    end
  end

endmodule

// File: rtl/cic_agc.sv
// cic_agc
// Automatic gain controller driving the CIC decimator's output shift.
// Block-peak measurement, fast attack, held slow decay, settle window after
// every gain change; manual mode passes the software gain straight through.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   agc_en       : 1 = automatic, 0 = manual
//   manual_gain  : manual gain, also the seed when automatic mode starts
//   hi_thresh    : overload magnitude threshold (unsigned, BITS-1)
//   lo_thresh    : quiet magnitude threshold (unsigned, BITS-1)
//   cic_x        : signed decimated sample
//   cic_tick     : one-cycle sample-valid strobe
//   gain         : registered gain to the CIC
//   gain_update  : one-cycle pulse coincident with a new gain value
//   peak         : peak magnitude of the last completed block
//   clip         : full-scale seen in the last completed block
module cic_agc
  import cic_agc_pkg::*;
#(
  parameter int BITS           = 16,
  parameter int GAIN_BITS      = 8,
  parameter int GAIN_MAX       = 59,
  parameter int BLOCK_LEN      = 64,
  parameter int HOLD_BLOCKS    = 8,
  parameter int SETTLE_SAMPLES = 6,
  parameter int ATTACK_STEP    = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 agc_en,
  input  logic [GAIN_BITS-1:0] manual_gain,
  input  logic [BITS-2:0]      hi_thresh,
  input  logic [BITS-2:0]      lo_thresh,
  input  logic [BITS-1:0]      cic_x,
  input  logic                 cic_tick,
  output logic [GAIN_BITS-1:0] gain,
  output logic                 gain_update,
  output logic [BITS-2:0]      peak,
  output logic                 clip
);

  localparam int GW     = GAIN_BITS + 1;
  localparam int CNT_W  = ctr_width(BLOCK_LEN);
  localparam int HOLD_W = ctr_width(HOLD_BLOCKS);
  localparam int SET_W  = ctr_width(SETTLE_SAMPLES);

  agc_state_e           state_q, state_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic                 gain_update_q, gain_update_d;
  logic [BITS-2:0]      peak_q, peak_d;
  logic                 clip_q, clip_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SET_W-1:0]     settle_q, settle_d;

  logic [GW-1:0]        gain_ext, dec_val, inc_val;
  logic [HOLD_W-1:0]    hold_inc;
  logic [GAIN_BITS-1:0] manual_clamped;
  logic [GAIN_BITS-1:0] decide_gain;
  logic [HOLD_W-1:0]    decide_hold;
  logic                 decide_change;
  logic                 last_sample;
  logic                 measuring;
  logic                 trk_tick, trk_clear;
  logic [BITS-2:0]      run_peak;
  logic                 run_clip;

  // Gain arithmetic is one bit wider so the attack step can go below zero
  // and be clamped instead of wrapping.
  assign gain_ext       = {1'b0, gain_q};
  assign dec_val        = gain_ext - GW'(ATTACK_STEP);
  assign inc_val        = gain_ext + GW'(1);
  assign hold_inc       = hold_q + HOLD_W'(1);
  assign manual_clamped = (manual_gain > GAIN_BITS'(GAIN_MAX)) ? GAIN_BITS'(GAIN_MAX) : manual_gain;

  // Gain decision for the latched block, plus whether the tracker should be
  // accumulating this cycle. Kept apart from the FSM so the tracker control
  // never depends on the tracker's own combinational output.
  always_comb begin
    decide_gain = gain_q;
    decide_hold = hold_q;
    if ((peak_q >= hi_thresh) || clip_q) begin
      decide_hold = '0;
      decide_gain = (gain_ext < GW'(ATTACK_STEP)) ? '0 : GAIN_BITS'(dec_val);
    end else if (peak_q < lo_thresh) begin
      if (hold_inc == HOLD_W'(HOLD_BLOCKS)) begin
        decide_hold = '0;
        decide_gain = (inc_val > GW'(GAIN_MAX)) ? GAIN_BITS'(GAIN_MAX) : GAIN_BITS'(inc_val);
      end else begin
        decide_hold = hold_inc;
      end
    end else begin
      decide_hold = '0;
    end
    decide_change = (decide_gain != gain_q);
    last_sample   = (cnt_q == CNT_W'(BLOCK_LEN - 1));
    // A tick during DECIDE already belongs to the next block when no settle follows.
    measuring     = agc_en && ((state_q == MEASURE) || ((state_q == DECIDE) && !decide_change));
    trk_tick      = cic_tick && measuring;
    trk_clear     = !measuring || ((state_q == MEASURE) && cic_tick && last_sample);
  end

  cic_agc_peak #(
    .BITS(BITS)
  ) u_peak (
    .CLK      (CLK),
    .RST      (RST),
    .sample   (cic_x),
    .tick     (trk_tick),
    .clear    (trk_clear),
    .run_peak (run_peak),
    .run_clip (run_clip)
  );

  // Controller FSM: dropping agc_en wins from any state and hands the gain
  // straight to the clamped manual value.
  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    peak_d   = peak_q;
    clip_d   = clip_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    settle_d = settle_q;
    if (!agc_en) begin
      state_d  = IDLE;
      gain_d   = manual_clamped;
      cnt_d    = '0;
      hold_d   = '0;
      settle_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = MEASURE;
          cnt_d    = '0;
          hold_d   = '0;
          settle_d = '0;
        end
        MEASURE: begin
          if (cic_tick) begin
            if (last_sample) begin
              peak_d  = run_peak;
              clip_d  = run_clip;
              cnt_d   = '0;
              state_d = DECIDE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DECIDE: begin
          gain_d = decide_gain;
          hold_d = decide_hold;
          if (decide_change) begin
            state_d  = SETTLE;
            clip_d   = 1'b0;
            settle_d = cic_tick ? SET_W'(1) : '0;
          end else begin
            state_d = MEASURE;
            cnt_d   = cic_tick ? CNT_W'(1) : '0;
          end
        end
        SETTLE: begin
          if (cic_tick) begin
            if (settle_q == SET_W'(SETTLE_SAMPLES - 1)) begin
              state_d  = MEASURE;
              settle_d = '0;
            end else begin
              settle_d = settle_q + SET_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    gain_update_d = (gain_d != gain_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      gain_q        <= '0;
      gain_update_q <= 1'b0;
      peak_q        <= '0;
      clip_q        <= 1'b0;
      cnt_q         <= '0;
      hold_q        <= '0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      peak_q        <= peak_d;
      clip_q        <= clip_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      settle_q      <= settle_d;
    end
  end

  assign gain        = gain_q;
  assign gain_update = gain_update_q;
  assign peak        = peak_q;
  assign clip        = clip_q;

endmodule

// File: tb/tb_cic_agc.sv
// tb_cic_agc
// Self-checking bench for cic_agc: directed scenarios followed by random
// traffic, every cycle compared against a block-level behavioural model.
module tb_cic_agc;

  localparam int BITS        = 16;
  localparam int GAIN_BITS   = 8;
  localparam int GAIN_MAX    = 59;
  localparam int BLOCK_LEN   = 4;
  localparam int HOLD_BLOCKS = 2;
  localparam int SETTLE_LEN  = 2;
  localparam int ATTACK      = 2;
  localparam int HI_TH       = 16384;
  localparam int LO_TH       = 4096;

  logic                 CLK;
  logic                 RST;
  logic                 agc_en;
  logic [GAIN_BITS-1:0] manual_gain;
  logic [BITS-2:0]      hi_thresh;
  logic [BITS-2:0]      lo_thresh;
  logic [BITS-1:0]      cic_x;
  logic                 cic_tick;
  logic [GAIN_BITS-1:0] gain;
  logic                 gain_update;
  logic [BITS-2:0]      peak;
  logic                 clip;

  int checkCount = 0;
  int errorCount = 0;
  int driveMg    = 0;

  // Reference model state: whole blocks of samples are kept in a queue and
  // judged only once complete.
  int mGain, mPeak, mQuiet, mSettleLeft;
  bit mUpdate, mClip, mAuto, mDecide;
  int mBlock[$];

  cic_agc #(
    .BITS(BITS), .GAIN_BITS(GAIN_BITS), .GAIN_MAX(GAIN_MAX),
    .BLOCK_LEN(BLOCK_LEN), .HOLD_BLOCKS(HOLD_BLOCKS),
    .SETTLE_SAMPLES(SETTLE_LEN), .ATTACK_STEP(ATTACK)
  ) dut (
    .CLK(CLK), .RST(RST), .agc_en(agc_en), .manual_gain(manual_gain),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh), .cic_x(cic_x),
    .cic_tick(cic_tick), .gain(gain), .gain_update(gain_update),
    .peak(peak), .clip(clip)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int magOf(input int x);
    int m;
    m = (x < 0) ? -x : x;
    return (m > 32767) ? 32767 : m;
  endfunction

  task automatic judgeBlock();
    int g;
    g = mGain;
    if (mPeak >= HI_TH || mClip) begin
      g = g - ATTACK;
      if (g < 0) g = 0;
      mQuiet = 0;
    end else if (mPeak < LO_TH) begin
      mQuiet++;
      if (mQuiet == HOLD_BLOCKS) begin
        g = g + 1;
        if (g > GAIN_MAX) g = GAIN_MAX;
        mQuiet = 0;
      end
    end else begin
      mQuiet = 0;
    end
    mGain = g;
  endtask

  task automatic modelStep(input bit rst, input bit en, input int mg, input int x, input bit tick);
    int oldGain, pk;
    bit cl;
    oldGain = mGain;
    if (rst) begin
      mGain = 0; mPeak = 0; mClip = 0; mQuiet = 0; mSettleLeft = 0;
      mAuto = 0; mDecide = 0; mBlock.delete();
      oldGain = 0;
    end else if (!en) begin
      mAuto = 0; mDecide = 0; mSettleLeft = 0; mQuiet = 0; mBlock.delete();
      mGain = (mg > GAIN_MAX) ? GAIN_MAX : mg;
    end else if (!mAuto) begin
      mAuto = 1; mQuiet = 0; mDecide = 0; mSettleLeft = 0; mBlock.delete();
    end else if (mDecide) begin
      mDecide = 0;
      judgeBlock();
      if (mGain != oldGain) begin
        mClip = 0;
        mSettleLeft = SETTLE_LEN;
        if (tick) mSettleLeft--;
      end else if (tick) begin
        mBlock.push_back(x);
      end
    end else if (mSettleLeft > 0) begin
      if (tick) mSettleLeft--;
    end else if (tick) begin
      mBlock.push_back(x);
      if (mBlock.size() == BLOCK_LEN) begin
        pk = 0; cl = 0;
        foreach (mBlock[k]) begin
          if (magOf(mBlock[k]) > pk) pk = magOf(mBlock[k]);
          if (mBlock[k] == -32768 || mBlock[k] == 32767) cl = 1;
        end
        mPeak = pk; mClip = cl;
        mBlock.delete();
        mDecide = 1;
      end
    end
    mUpdate = rst ? 1'b0 : (mGain != oldGain);
  endtask

  // One clock of stimulus; outputs are compared 1 ns after the edge.
  task automatic applyStimulus(input bit rst, input bit en, input int mg, input int x, input bit tick);
    RST = rst;
    agc_en = en;
    manual_gain = GAIN_BITS'(mg);
    cic_x = BITS'(x);
    cic_tick = tick;
    modelStep(rst, en, mg, x, tick);
    @(posedge CLK);
    #1;
    checkOutput("gain", int'(gain), mGain);
    checkOutput("gain_update", int'(gain_update), int'(mUpdate));
    checkOutput("peak", int'(peak), mPeak);
    checkOutput("clip", int'(clip), int'(mClip));
  endtask

  task automatic sendTicks(input int x, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, driveMg, x, 1'b1);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b1, driveMg, 0, 1'b0);
  endtask

  task automatic quietThenDecide(input int x);
    sendTicks(x, BLOCK_LEN);
    idleCycle();
  endtask

  initial begin
    int regime, x, m;
    bit en, rst, tick;
    hi_thresh = (BITS-1)'(HI_TH);
    lo_thresh = (BITS-1)'(LO_TH);

    $display("[TB] reset and manual mode");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 20, 0, 1'b0);
    checkOutput("rst_gain", int'(gain), 0);
    checkOutput("rst_update", int'(gain_update), 0);
    checkOutput("rst_clip", int'(clip), 0);
    applyStimulus(1'b0, 1'b0, 20, 0, 1'b0);
    checkOutput("man_gain20", int'(gain), 20);
    checkOutput("man_pulse", int'(gain_update), 1);
    applyStimulus(1'b0, 1'b0, 20, 0, 1'b0);
    checkOutput("man_pulse_end", int'(gain_update), 0);
    applyStimulus(1'b0, 1'b0, 200, 0, 1'b0);
    checkOutput("man_clamp", int'(gain), 59);

    $display("[TB] attack");
    applyStimulus(1'b0, 1'b0, 20, 0, 1'b0);
    driveMg = 20;
    idleCycle();
    sendTicks(20000, 4);
    checkOutput("atk_peak", int'(peak), 20000);
    idleCycle();
    checkOutput("atk_gain", int'(gain), 18);
    checkOutput("atk_pulse", int'(gain_update), 1);
    sendTicks(20000, 2);
    checkOutput("atk_settle_gain", int'(gain), 18);

    $display("[TB] decay with hold");
    quietThenDecide(1000);
    checkOutput("hold1_gain", int'(gain), 18);
    checkOutput("hold1_pulse", int'(gain_update), 0);
    quietThenDecide(1000);
    checkOutput("hold2_gain", int'(gain), 19);
    checkOutput("hold2_pulse", int'(gain_update), 1);
    sendTicks(1000, 2);
    quietThenDecide(1000);
    quietThenDecide(8000);
    checkOutput("mid_peak", int'(peak), 8000);
    quietThenDecide(1000);
    checkOutput("mid_reset_gain", int'(gain), 19);
    quietThenDecide(1000);
    checkOutput("hold_after_mid", int'(gain), 20);
    sendTicks(1000, 2);

    $display("[TB] clip and lower bound");
    applyStimulus(1'b0, 1'b0, 1, 0, 1'b0);
    driveMg = 1;
    idleCycle();
    sendTicks(100, 1);
    sendTicks(-32768, 1);
    sendTicks(100, 2);
    checkOutput("clip_peak", int'(peak), 32767);
    checkOutput("clip_flag", int'(clip), 1);
    idleCycle();
    checkOutput("clip_gain", int'(gain), 0);
    sendTicks(0, 2);
    quietThenDecide(20000);
    checkOutput("floor_gain", int'(gain), 0);
    checkOutput("floor_pulse", int'(gain_update), 0);
    sendTicks(1000, 4);
    checkOutput("floor_no_settle", int'(peak), 1000);
    idleCycle();

    $display("[TB] upper bound");
    applyStimulus(1'b0, 1'b0, 59, 0, 1'b0);
    driveMg = 59;
    idleCycle();
    for (int b = 0; b < 3; b++) begin
      quietThenDecide(1000);
      checkOutput("ceil_gain", int'(gain), 59);
      checkOutput("ceil_pulse", int'(gain_update), 0);
    end

    $display("[TB] mode switch and mid-block reset");
    sendTicks(1000, 2);
    applyStimulus(1'b0, 1'b0, 30, 0, 1'b0);
    checkOutput("sw_gain", int'(gain), 30);
    driveMg = 30;
    idleCycle();
    sendTicks(20000, 2);
    checkOutput("sw_restart", int'(peak), 1000);
    sendTicks(20000, 2);
    checkOutput("sw_block", int'(peak), 20000);
    idleCycle();
    checkOutput("sw_attack", int'(gain), 28);
    sendTicks(0, 2);
    sendTicks(20000, 2);
    applyStimulus(1'b1, 1'b1, 30, 0, 1'b0);
    checkOutput("midrst_gain", int'(gain), 0);
    checkOutput("midrst_peak", int'(peak), 0);

    $display("[TB] random traffic");
    en = 1'b1;
    regime = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 24 == 0) regime = int'($urandom_range(0, 3));
      rst = ($urandom_range(0, 499) == 0);
      if (en ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0)) begin
        en = ~en;
        driveMg = int'($urandom_range(0, 255));
      end
      tick = ($urandom_range(0, 2) != 0);
      case (regime)
        0: m = int'($urandom_range(0, 4095));
        1: m = int'($urandom_range(4096, 16383));
        2: m = int'($urandom_range(16384, 32000));
        default: m = ($urandom_range(0, 3) == 0) ? 32768 : int'($urandom_range(0, 32767));
      endcase
      x = ($urandom_range(0, 1) == 1) ? m : -m;
      if (x == 32768) x = 32767;
      applyStimulus(rst, en, driveMg, x, tick);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/cic_agc.md
Name: cic_agc

Overview:
- Automatic gain controller for the CIC decimator's variable output shift.
- Observes the decimated samples (`x_out` / `out_tick`) and drives the decimator's `gain` input.
- Control law: block-peak measurement with fast attack, held slow decay and a post-change settle window.
- Manual override passes a software gain straight through.
- Sits between the CIC decimator and the downstream AM demodulator / audio path.

Parameters:
- BITS, 16, width of CIC output samples
- GAIN_BITS, 8, width of gain control word
- GAIN_MAX, 59, maximum legal gain (WIDTH - BITS - 1 of the decimator)
- BLOCK_LEN, 64, CIC output samples per peak-measurement block
- HOLD_BLOCKS, 8, consecutive quiet blocks required before one gain increment
- SETTLE_SAMPLES, 6, samples ignored after any gain change (comb pipeline flush)
- ATTACK_STEP, 2, gain decrement applied on an overload block

Ports:
- CLK, in, 1, system clock
- RST, in, 1, synchronous reset, active-high
- agc_en, in, 1, 1 = automatic, 0 = manual
- manual_gain, in, GAIN_BITS, gain used in manual mode; seed on AGC entry
- hi_thresh, in, BITS-1, unsigned overload magnitude threshold
- lo_thresh, in, BITS-1, unsigned quiet magnitude threshold (lo_thresh < hi_thresh)
- cic_x, in, BITS, signed decimated sample
- cic_tick, in, 1, sample-valid strobe, one cycle
- gain, out, GAIN_BITS, registered gain to the CIC
- gain_update, out, 1, one-cycle pulse, coincident with a new gain value
- peak, out, BITS-1, peak of the last completed block
- clip, out, 1, sticky per block; set if any sample in the block equals -2^(BITS-1) or 2^(BITS-1)-1

Behaviour:
- Reset: state=IDLE.
  - gain, peak, hold counter, sample counter, settle counter all 0.
  - gain_update=0, clip=0.
  - RST overrides everything, mid-block included.
- Magnitude:
  - mag = |cic_x| as unsigned BITS-1 bits.
  - -2^(BITS-1) saturates to 2^(BITS-1)-1.
  - Both full-scale codes also set clip.
- IDLE (agc_en=0):
  - gain <= min(manual_gain, GAIN_MAX) every cycle.
  - gain_update pulses on any cycle the registered value changes.
  - Ticks are ignored.
  - When agc_en=1: go to MEASURE with counters and running peak cleared; gain is retained.
- MEASURE:
  - On each cic_tick: run_peak <= max(run_peak, mag) and count++.
  - On the BLOCK_LEN-th tick, including that sample:
    - latch peak and clip;
    - clear run_peak and count;
    - go to DECIDE.
- DECIDE (exactly 1 cycle):
  - If peak >= hi_thresh or clip:
    - gain <= max(gain - ATTACK_STEP, 0), saturating;
    - hold <= 0.
  - Else if peak < lo_thresh:
    - hold++;
    - when hold reaches HOLD_BLOCKS: gain <= min(gain + 1, GAIN_MAX) and hold <= 0.
  - Else: hold <= 0.
  - If gain actually changed:
    - gain_update=1 on the cycle the new gain is visible, 2 cycles after the final tick;
    - next state is SETTLE.
  - If gain did not change (including saturation at 0 or GAIN_MAX): no pulse; next state is MEASURE.
  - A tick arriving during DECIDE counts as sample 1 of the next block, or settle sample 1.
- SETTLE:
  - Count SETTLE_SAMPLES ticks without measuring.
  - Then go to MEASURE with a fresh block.
  - clip is cleared on entry.
- agc_en falling in any state:
  - go to IDLE on the next cycle;
  - in-flight block is discarded;
  - peak keeps its last value.
- Arithmetic:
  - gain math is done at GAIN_BITS+1 bits, then clamped to [0, GAIN_MAX];
  - gain never exceeds GAIN_MAX in any mode.

Decomposition:
- Shared header/localparams file `cic_agc_defs`:
  - state encodings IDLE/MEASURE/DECIDE/SETTLE (2 bits);
  - full-scale constants;
  - counter widths via clog2 of BLOCK_LEN, HOLD_BLOCKS, SETTLE_SAMPLES.
- One sub-module, `cic_agc_peak`:
  - abs/saturate plus running-max tracker with clip detect;
  - inputs: sample, tick, clear; outputs: run_peak, run_clip.

Test Plan:
Test configuration for all scenarios: BLOCK_LEN=4, HOLD_BLOCKS=2, SETTLE_SAMPLES=2, ATTACK_STEP=2, hi_thresh=16384, lo_thresh=4096.
1. Reset/manual: RST high for 3 cycles, then agc_en=0, manual_gain=20.
   - After reset: gain=0, gain_update=0, clip=0.
   - Then gain=20 with one gain_update pulse.
   - manual_gain=200 → gain=59.
2. Attack: seed gain=20, agc_en=1, 4 ticks of cic_x=20000.
   - peak=20000.
   - gain=18 with gain_update 2 cycles after the 4th tick.
   - Next 2 ticks are ignored (SETTLE).
3. Decay with hold: gain=18, repeated blocks of cic_x=1000.
   - gain=19 only after the 2nd quiet block.
   - No change after the 1st quiet block.
   - A mid-level block (8000) resets hold.
4. Clip/saturation: gain=1, one block containing -32768.
   - peak=32767, clip=1, gain=0.
   - A further overload block leaves gain=0 with no pulse and no SETTLE.
5. Upper bound: gain=59, quiet blocks → gain stays 59, no gain_update.
6. Mode switch mid-block: agc_en drops after 2 of 4 ticks with manual_gain=30.
   - Next cycle: IDLE, gain=30.
   - Re-enable: block count restarts at 0.
   - RST asserted mid-block: all outputs return to reset values next cycle.
